// File: rtl/ir_sense_seq.sv
// Four-sensor IR reflectance sweep sequencer: lights each emitter, waits for it to
// settle, requests an A2D conversion on the matching channel and reports the result.
module ir_sense_seq #(
  parameter int SETTLE_CYC = 1024,
  parameter int CNV_TMO    = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt,
  input  logic [7:0]  duty_cfg,
  output logic [7:0]  ir_duty,
  output logic [3:0]  ir_en,
  output logic        cnv_req,
  output logic [1:0]  chnl,
  input  logic        cnv_done,
  input  logic [11:0] a2d_res,
  output logic [11:0] sens_val,
  output logic [1:0]  sens_idx,
  output logic        sens_vld,
  output logic        sweep_done,
  output logic        busy,
  output logic        tmo_err,
  output logic [2:0]  state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SETTLE = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_STORE  = 3'd4;

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
  localparam logic [15:0] TMO_LAST    = 16'(CNV_TMO - 1);

  logic [2:0]  state;
  logic [1:0]  idx;
  logic [15:0] settle_cnt;
  logic [15:0] tmo_cnt;
  logic [7:0]  duty_q;

  // Handshake: cnv_req is a one-cycle request; cnv_done is a one-cycle strobe that is
  // only honoured in WAIT, where a2d_res is captured in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= 2'd0;
      settle_cnt <= 16'd0;
      tmo_cnt    <= 16'd0;
      duty_q     <= 8'd0;
      sens_val   <= 12'd0;
      sens_idx   <= 2'd0;
      tmo_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (strt) begin
            state      <= S_SETTLE;
            duty_q     <= duty_cfg;
            idx        <= 2'd0;
            tmo_err    <= 1'b0;
            settle_cnt <= 16'd0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state      <= S_REQ;
            settle_cnt <= 16'd0;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end
        S_REQ: begin
          state   <= S_WAIT;
          tmo_cnt <= 16'd0;
        end
        S_WAIT: begin
          // A strobe landing on the last allowed cycle still counts as a good result.
          if (cnv_done) begin
            sens_val <= a2d_res;
            sens_idx <= idx;
            state    <= S_STORE;
          end else if (tmo_cnt == TMO_LAST) begin
            sens_val <= 12'hFFF;
            sens_idx <= idx;
            tmo_err  <= 1'b1;
            state    <= S_STORE;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end
        S_STORE: begin
          if (idx == 2'd3) begin
            state <= S_IDLE;
          end else begin
            idx        <= idx + 2'd1;
            settle_cnt <= 16'd0;
            state      <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    ir_en = 4'd0;
    if (state == S_SETTLE || state == S_REQ || state == S_WAIT)
      ir_en = 4'd1 << idx;
  end

  assign ir_duty    = (state == S_IDLE) ? 8'd0 : duty_q;
  assign cnv_req    = (state == S_REQ);
  assign chnl       = idx;
  assign sens_vld   = (state == S_STORE);
  assign sweep_done = (state == S_STORE) && (idx == 2'd3);
  assign busy       = (state != S_IDLE);
  assign state_dbg  = state;

endmodule

// File: tb/tb_ir_sense_seq.sv
// Bench for ir_sense_seq: an A2D responder model with per-sensor delay, a result
// scoreboard fed when each sweep is launched, and directed sweep scenarios.
module tb_ir_sense_seq;

  localparam int SC  = 4;
  localparam int TMO = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        strt = 1'b0;
  logic [7:0]  duty_cfg = 8'd0;
  logic [7:0]  ir_duty;
  logic [3:0]  ir_en;
  logic        cnv_req;
  logic [1:0]  chnl;
  logic        cnv_done;
  logic [11:0] a2d_res;
  logic [11:0] sens_val;
  logic [1:0]  sens_idx;
  logic        sens_vld;
  logic        sweep_done;
  logic        busy;
  logic        tmo_err;
  logic [2:0]  state_dbg;

  ir_sense_seq #(.SETTLE_CYC(SC), .CNV_TMO(TMO)) dut (
    .clk(clk), .rst(rst), .strt(strt), .duty_cfg(duty_cfg), .ir_duty(ir_duty),
    .ir_en(ir_en), .cnv_req(cnv_req), .chnl(chnl), .cnv_done(cnv_done),
    .a2d_res(a2d_res), .sens_val(sens_val), .sens_idx(sens_idx), .sens_vld(sens_vld),
    .sweep_done(sweep_done), .busy(busy), .tmo_err(tmo_err), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // A2D responder: answers cnv_req after dly[chnl] cycles (0 = never answers)
  int          dly[4];
  int          pend = 0;
  logic [1:0]  pend_ch = 2'd0;
  logic [11:0] res_base = 12'h100;
  logic        stray_req = 1'b0;

  initial begin
    cnv_done = 1'b0;
    a2d_res  = 12'd0;
    forever begin
      @(posedge clk); #1;
      cnv_done = 1'b0;
      a2d_res  = 12'($urandom);
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          cnv_done = 1'b1;
          a2d_res  = res_base + 12'(pend_ch);
        end
      end
      if (stray_req) begin
        cnv_done  = 1'b1;
        a2d_res   = 12'h5A5;
        stray_req = 1'b0;
      end
      if (cnv_req && dly[chnl] != 0) begin
        pend    = dly[chnl];
        pend_ch = chnl;
      end
    end
  end

  // scoreboard
  logic [13:0] exp_q[$];
  logic [3:0]  en_q[$];
  logic [7:0]  exp_duty = 8'd0;
  int          sweep_cnt = 0;
  int          vld_cnt = 0;
  int          strt_cyc = 0;
  int          exp_lat = 0;
  logic        lat_pend = 1'b0;

  always @(negedge clk) begin
    logic [13:0] e;
    logic [3:0]  en;
    if (!rst) begin
      if (cnv_req) begin
        if (en_q.size() == 0) check("unexp_req", 1, 0);
        else begin
          en = en_q.pop_front();
          check("ir_en", ir_en, en);
          check("ir_duty", ir_duty, exp_duty);
        end
      end
      if (sens_vld) begin
        vld_cnt++;
        if (lat_pend) begin
          check("latency", cyc - strt_cyc, exp_lat);
          lat_pend = 1'b0;
        end
        if (exp_q.size() == 0) check("unexp_vld", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("sens", {sens_idx, sens_val}, e);
          check("sweep_done", sweep_done, e[13:12] == 2'd3);
        end
      end else if (sweep_done) begin
        check("stray_done", 1, 0);
      end
      if (sweep_done) sweep_cnt++;
    end
  end

  // driver: mode 0 plain, 1 strt while busy, 2 reset in WAIT of sensor 2, 3 stray cnv_done
  task automatic run_sweep(input logic [7:0] duty, input int d0, input int d1,
                           input int d2, input int d3, input int mode);
    int   s0, v0, n;
    logic exp_tmo, inj_a, inj_b, done;
    dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    exp_tmo = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (dly[i] >= 1 && dly[i] <= TMO) exp_q.push_back({2'(i), res_base + 12'(i)});
      else begin
        exp_q.push_back({2'(i), 12'hFFF});
        exp_tmo = 1'b1;
      end
      en_q.push_back(4'd1 << i);
    end
    exp_duty = duty;
    exp_lat  = SC + ((d0 >= 1 && d0 <= TMO) ? d0 : TMO) + 2;
    s0 = sweep_cnt;
    v0 = vld_cnt;
    @(negedge clk); #1;
    duty_cfg = duty;
    strt     = 1'b1;
    strt_cyc = cyc;
    lat_pend = 1'b1;
    @(negedge clk); #1;
    strt     = 1'b0;
    duty_cfg = ~duty;
    check("start_tmo_clr", tmo_err, 0);
    check("start_busy", busy, 1);
    check("start_duty", ir_duty, duty);
    inj_a = 1'b0; inj_b = 1'b0; done = 1'b0;
    n = 0;
    while (!done && n < 500) begin
      @(negedge clk); #1;
      n++;
      strt = 1'b0;
      if (sweep_cnt != s0) done = 1'b1;
      else if (mode == 1 && state_dbg == 3'd1 && chnl == 2'd1 && !inj_a) begin
        strt = 1'b1; inj_a = 1'b1;
      end else if (mode == 1 && state_dbg == 3'd3 && chnl == 2'd1 && !inj_b) begin
        strt = 1'b1; inj_b = 1'b1;
      end else if (mode == 3 && state_dbg == 3'd1 && chnl == 2'd0 && !inj_a) begin
        stray_req = 1'b1; inj_a = 1'b1;
      end else if (mode == 2 && state_dbg == 3'd3 && chnl == 2'd2) begin
        rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        check("rst_ir_en", ir_en, 0);
        check("rst_ir_duty", ir_duty, 0);
        check("rst_cnv_req", cnv_req, 0);
        check("rst_sens", {sens_idx, sens_val, sens_vld, sweep_done}, 0);
        check("rst_busy_tmo", {busy, tmo_err, chnl}, 0);
        exp_q.delete();
        en_q.delete();
        lat_pend = 1'b0;
        repeat (30) @(negedge clk);
        #1;
        check("rst_no_vld", vld_cnt - v0, 2);
        check("rst_no_done", sweep_cnt - s0, 0);
        done = 1'b1;
      end
    end
    if (!done) check("sweep_timeout", 0, 1);
    if (mode != 2) begin
      @(negedge clk); #1;
      check("end_busy", busy, 0);
      check("end_idle_out", {ir_en, ir_duty}, 0);
      check("end_q_empty", exp_q.size(), 0);
      check("end_tmo_err", tmo_err, exp_tmo);
      if (mode == 1 || mode == 3) begin
        repeat (40) @(negedge clk);
        #1;
      end
      check("sweep_count", sweep_cnt - s0, 1);
      check("vld_count", vld_cnt - v0, 4);
    end
  endtask

  initial begin
    dly[0] = 0; dly[1] = 0; dly[2] = 0; dly[3] = 0;
    repeat (3) @(negedge clk);
    check("rst_state", {busy, ir_en, ir_duty, cnv_req}, 0);
    check("rst_regs", {sens_val, sens_idx, sens_vld, sweep_done, tmo_err}, 0);
    #1 rst = 1'b0;

    res_base = 12'h100;
    run_sweep(8'h80, 3, 3, 3, 3, 0);
    run_sweep(8'h40, 3, 3, 0, 3, 0);
    repeat (10) @(negedge clk);
    check("tmo_sticky", tmo_err, 1);
    run_sweep(8'hC3, 2, 4, 1, 3, 1);
    run_sweep(8'h00, TMO, TMO, TMO, TMO, 3);
    run_sweep(8'h5A, 3, 3, 3, 3, 2);
    res_base = 12'h100;
    run_sweep(8'h11, 1, 2, 3, 4, 0);
    for (int k = 0; k < 3; k++) begin
      res_base = 12'($urandom_range(0, 12'hEF0));
      run_sweep(8'($urandom), $urandom_range(1, TMO + 1), $urandom_range(1, TMO + 1),
                $urandom_range(1, TMO + 1), $urandom_range(1, TMO + 1), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_sense_seq.md
IR_SENSE_SEQ -- requirements
Module: ir_sense_seq

Interface
REQ-001 Parameter SETTLE_CYC, default 1024: number of clk cycles the emitter is on before a conversion request; legal range 1..65535.
REQ-002 Parameter CNV_TMO, default 255: maximum number of clk cycles to wait for cnv_done; legal range 1..65535.
REQ-003 Port clk  input  1: single system clock; all logic is on its rising edge.
REQ-004 Port rst  input  1: synchronous, active-high reset.
REQ-005 Port strt  input  1: single-cycle request to start one 4-sensor sweep.
REQ-006 Port duty_cfg  input  8: IR emitter intensity for the sweep; sampled when the sweep starts.
REQ-007 Port ir_duty  output  8: duty value fed to the downstream 8-bit IR PWM generator.
REQ-008 Port ir_en  output  4: one-hot emitter enable; bit i gates the PWM onto emitter i.
REQ-009 Port cnv_req  output  1: single-cycle A2D conversion request.
REQ-010 Port chnl  output  2: A2D channel for the current sensor; equals the sensor index.
REQ-011 Port cnv_done  input  1: single-cycle A2D completion strobe.
REQ-012 Port a2d_res  input  12: A2D result; valid in the cycle cnv_done is high.
REQ-013 Port sens_val  output  12: last stored sensor result.
REQ-014 Port sens_idx  output  2: index of the sensor whose result is in sens_val.
REQ-015 Port sens_vld  output  1: one-cycle pulse; sens_val and sens_idx are new.
REQ-016 Port sweep_done  output  1: one-cycle pulse when the sweep completes.
REQ-017 Port busy  output  1: high whenever the state is not IDLE.
REQ-018 Port tmo_err  output  1: sticky flag; at least one conversion in the current or last sweep timed out.

Function
REQ-019 States: IDLE, SETTLE, REQ, WAIT, STORE; a registered 2-bit index idx selects the sensor.
REQ-020 IDLE with strt=1 -> SETTLE next cycle:
  - duty_cfg is latched into ir_duty.
  - idx is set to 0.
  - tmo_err is cleared.
  - the settle counter is cleared.
REQ-021 Outputs by state:
  - ir_en = (1 << idx) in SETTLE, REQ and WAIT; 0 in IDLE and STORE.
  - ir_duty holds the latched value in every non-IDLE state and reads 0 in IDLE.
  - chnl = idx in every state.
REQ-022 SETTLE counts clk cycles; after exactly SETTLE_CYC cycles in SETTLE, go to REQ.
REQ-023 REQ lasts exactly one cycle with cnv_req=1, then goes to WAIT; cnv_req is 0 in every other state.
REQ-024 WAIT, cnv_done=1 -> STORE; a2d_res from that cycle is captured.
REQ-025 WAIT, no cnv_done within CNV_TMO cycles -> STORE:
  - 12'hFFF is captured instead of a2d_res.
  - tmo_err is set.
  - if cnv_done and the timeout occur in the same cycle, cnv_done wins and no error is flagged.
REQ-026 STORE lasts one cycle:
  - sens_val and sens_idx update, with sens_vld=1 in the same cycle.
  - idx<3: increment idx, clear the settle counter, go to SETTLE.
  - idx=3: sweep_done=1 in the same cycle, go to IDLE.
REQ-027 Latency with cnv_done arriving D cycles after cnv_req: strt to the first sens_vld is SETTLE_CYC+D+2 cycles; sensors are spaced SETTLE_CYC+D+2 cycles apart.
REQ-028 strt while busy=1 is ignored; the sweep in progress is not restarted or extended.
REQ-029 cnv_done outside WAIT is ignored, and no result is stored.
REQ-030 duty_cfg changes during a sweep do not affect ir_duty until the next sweep starts.
REQ-031 duty_cfg=0 is legal; the sequencing is unchanged.
REQ-032 Counter widths: the settle and timeout counters are 16 bits and never wrap within a state.

Reset
REQ-033 With rst=1 at a clock edge, the next-cycle values are:
  - state=IDLE, idx=0, counters=0.
  - ir_duty=0, ir_en=0, cnv_req=0.
  - sens_val=0, sens_idx=0, sens_vld=0, sweep_done=0.
  - busy=0, tmo_err=0.
REQ-034 rst has priority over every other input, including mid-sweep. A result pending in WAIT is discarded, and no sens_vld or sweep_done is issued.

Verification
REQ-035 Normal sweep (SETTLE_CYC=4, duty_cfg=8'h80, cnv_done 3 cycles after each cnv_req, a2d_res=12'h100+idx):
  - 4 sens_vld pulses, idx 0..3, values 12'h100..12'h103.
  - ir_en sequence 1,2,4,8; ir_duty=8'h80 throughout.
  - sweep_done coincides with the 4th sens_vld; first sens_vld 9 cycles after strt.
REQ-036 Timeout (CNV_TMO=5, no cnv_done for sensor 2):
  - sensor 2 reports 12'hFFF and tmo_err=1.
  - sensor 3 still completes.
  - tmo_err stays 1 after the sweep and clears on the next strt.
REQ-037 Busy ignore: strt pulsed during SETTLE and WAIT of sensor 1 -> exactly one sweep_done, 4 sens_vld.
REQ-038 Boundary: cnv_done asserted in the same cycle the timeout expires -> a2d_res stored, tmo_err=0. Stray cnv_done in SETTLE -> no sens_vld.
REQ-039 Reset mid-sweep: rst=1 during WAIT of sensor 2 ->
  - next cycle all outputs are at reset values.
  - no sens_vld or sweep_done follows.
  - a new strt runs a full sweep from idx 0.
